// File: rtl/systemizer_sched.sv
// rtl/systemizer_sched.sv - job scheduler around one systemizer: load, start, retry on fail, unload
module systemizer_sched #(
  parameter int N         = 20,
  parameter int M         = 1,
  parameter int L         = 200,
  parameter int K         = 400,
  parameter int MAX_TRIES = 8,
  parameter int TIMEOUT   = 65535,
  localparam int WORDS    = L * K / N,
  localparam int AW       = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int TW       = $clog2(MAX_TRIES + 1),
  localparam int DW       = N * M
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          job_req,
  input  logic          abort,
  output logic          busy,
  output logic          job_done,
  output logic          job_ok,
  output logic [TW-1:0] tries,
  output logic          reload_req,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          sys_start,
  input  logic          sys_success,
  input  logic          sys_fail,
  output logic          sys_wr_en,
  output logic [AW-1:0] sys_wr_addr,
  output logic [DW-1:0] sys_data_in,
  output logic          sys_rd_en,
  output logic [AW-1:0] sys_rd_addr,
  input  logic [DW-1:0] sys_data_out
);

  localparam int CW  = AW + 1;
  localparam int TW1 = TW + 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_UNLOAD,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   addr;
  logic [CW-1:0]   pop_cnt;
  logic [WDW-1:0]  wd;
  logic            ok_q;
  logic            reload_q;
  logic [DW-1:0]   fifo_head;
  logic [DW-1:0]   fifo_tail;
  logic [1:0]      fifo_cnt;
  logic            rd_pend;

  logic            wr_fire;
  logic            last_wr;
  logic            wd_expired;
  logic            run_fail;
  logic            last_try;
  logic [2:0]      occ;
  logic            rd_fire;
  logic            pop;
  logic            push;
  logic            last_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    wr_fire     = (state == S_LOAD) && in_valid && !abort;
    last_wr     = wr_fire && (addr == CW'(WORDS - 1));
    wd_expired  = (wd == WDW'(TIMEOUT));
    // fail wins over a simultaneous success
    run_fail    = (state == S_RUN) && (sys_fail || wd_expired);
    last_try    = (({1'b0, tries} + TW1'(1)) == TW1'(MAX_TRIES));
    occ         = {1'b0, fifo_cnt} + {2'b00, rd_pend};
    rd_fire     = (state == S_UNLOAD) && !abort && (occ < 3'd2) && (addr < CW'(WORDS));
    pop         = (state == S_UNLOAD) && !abort && (fifo_cnt != 2'd0) && out_ready;
    push        = rd_pend && !abort;
    last_pop    = pop && (pop_cnt == CW'(WORDS - 1));

    busy        = (state != S_IDLE);
    in_ready    = (state == S_LOAD) && !abort;
    sys_wr_en   = wr_fire;
    sys_wr_addr = addr[AW-1:0];
    sys_data_in = wr_fire ? in_data : '0;
    sys_rd_en   = rd_fire;
    sys_rd_addr = addr[AW-1:0];
    sys_start   = (state == S_START) && !abort;
    job_done    = (state == S_DONE) && !abort;
    job_ok      = job_done && ok_q;
    out_valid   = (fifo_cnt != 2'd0);
    out_data    = fifo_head;
    reload_req  = reload_q;

    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (job_req) state_nxt = S_LOAD;
        S_LOAD:   if (last_wr) state_nxt = S_START;
        S_START:  state_nxt = S_RUN;
        S_RUN: begin
          if (run_fail)         state_nxt = last_try ? S_DONE : S_LOAD;
          else if (sys_success) state_nxt = S_UNLOAD;
        end
        S_UNLOAD: if (last_pop) state_nxt = S_DONE;
        S_DONE:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr      <= '0;
      pop_cnt   <= '0;
      wd        <= '0;
      tries     <= '0;
      ok_q      <= 1'b0;
      reload_q  <= 1'b0;
      fifo_head <= '0;
      fifo_tail <= '0;
      fifo_cnt  <= 2'd0;
      rd_pend   <= 1'b0;
    end else begin
      reload_q <= 1'b0;
      if (abort) begin
        // flush everything; a read returning next cycle is dropped since rd_pend clears
        addr      <= '0;
        pop_cnt   <= '0;
        wd        <= '0;
        ok_q      <= 1'b0;
        fifo_head <= '0;
        fifo_tail <= '0;
        fifo_cnt  <= 2'd0;
        rd_pend   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (job_req) begin
              addr  <= '0;
              tries <= '0;
              ok_q  <= 1'b0;
            end
          end
          S_LOAD: begin
            if (wr_fire) addr <= last_wr ? '0 : addr + CW'(1);
          end
          S_START: wd <= '0;
          S_RUN: begin
            if (run_fail) begin
              tries <= (tries == TW'(MAX_TRIES)) ? tries : tries + TW'(1);
              addr  <= '0;
              if (last_try) ok_q     <= 1'b0;
              else          reload_q <= 1'b1;
            end else if (sys_success) begin
              addr     <= '0;
              pop_cnt  <= '0;
              fifo_cnt <= 2'd0;
              rd_pend  <= 1'b0;
            end else if (!wd_expired) begin
              wd <= wd + WDW'(1);
            end
          end
          S_UNLOAD: begin
            if (rd_fire) addr <= addr + CW'(1);
            rd_pend <= rd_fire;
            if (pop)      pop_cnt <= pop_cnt + CW'(1);
            if (last_pop) ok_q    <= 1'b1;
            // head register holds out_data steady while the consumer stalls
            case ({push, pop})
              2'b10: begin
                if (fifo_cnt == 2'd0) fifo_head <= sys_data_out;
                else                  fifo_tail <= sys_data_out;
                fifo_cnt <= fifo_cnt + 2'd1;
              end
              2'b01: begin
                fifo_head <= fifo_tail;
                fifo_cnt  <= fifo_cnt - 2'd1;
              end
              2'b11: begin
                if (fifo_cnt == 2'd1) begin
                  fifo_head <= sys_data_out;
                end else begin
                  fifo_head <= fifo_tail;
                  fifo_tail <= sys_data_out;
                end
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_systemizer_sched.sv
// tb/tb_systemizer_sched.sv - randomized scoreboard bench for systemizer_sched
module tb_systemizer_sched;

  localparam int K_S = 0;
  localparam int K_F = 1;
  localparam int K_W = 2;
  localparam int K_B = 3;

  logic       clk, rst, job_req, abort;
  logic       busy, job_done, job_ok, reload_req;
  logic [1:0] tries;
  logic       in_valid, in_ready;
  logic [3:0] in_data;
  logic       out_valid, out_ready;
  logic [3:0] out_data;
  logic       sys_start, sys_success, sys_fail;
  logic       sys_wr_en, sys_rd_en;
  logic [4:0] sys_wr_addr, sys_rd_addr;
  logic [3:0] sys_data_in, sys_data_out;
  logic [28:0] outs;

  systemizer_sched #(.N(4), .M(1), .L(8), .K(16), .MAX_TRIES(3), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .job_req(job_req), .abort(abort), .busy(busy),
    .job_done(job_done), .job_ok(job_ok), .tries(tries), .reload_req(reload_req),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sys_start(sys_start), .sys_success(sys_success), .sys_fail(sys_fail),
    .sys_wr_en(sys_wr_en), .sys_wr_addr(sys_wr_addr), .sys_data_in(sys_data_in),
    .sys_rd_en(sys_rd_en), .sys_rd_addr(sys_rd_addr), .sys_data_out(sys_data_out)
  );

  assign outs = {busy, job_done, job_ok, tries, reload_req, in_ready, out_valid, out_data,
                 sys_start, sys_wr_en, sys_wr_addr, sys_data_in, sys_rd_en, sys_rd_addr};

  // systemizer memory: write port plus a read port with one cycle of latency
  logic [3:0] mem [32];
  always @(posedge clk) begin
    if (sys_wr_en) mem[sys_wr_addr] <= sys_data_in;
    if (sys_rd_en) sys_data_out <= mem[sys_rd_addr];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];
  bit         exp_ok[$];
  int         exp_tr[$];
  int start_cnt = 0, reload_cnt = 0, done_cnt = 0;
  int wr_seen = 0, rd_issued = 0, popped = 0;
  int rdy_mode = 0, stall_left = 0;
  bit prev_stall = 0;
  logic [3:0] prev_data = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // monitor: samples 2 time units after the falling edge, after drivers have settled
  initial begin
    forever begin
      @(negedge clk);
      #2;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (stall_left > 0 && out_valid) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'($urandom_range(0, 1));
          end
        end
      endcase
      if (!rst || abort) begin
        prev_stall = 0;
      end else begin
        if (sys_start)  start_cnt++;
        if (reload_req) reload_cnt++;
        if (sys_wr_en) begin
          chk("wr_addr", 64'(sys_wr_addr), 64'(wr_seen % 32));
          wr_seen++;
        end
        if (sys_rd_en) begin
          chk("rd_addr", 64'(sys_rd_addr), 64'(rd_issued % 32));
          chk("rd_outstanding_le2", 64'((rd_issued + 1 - popped) <= 2), 64'(1));
          rd_issued++;
        end
        if (prev_stall) begin
          chk("stall_valid_held", 64'(out_valid), 64'(1));
          chk("stall_data_held", 64'(out_data), 64'(prev_data));
        end
        if (out_valid && out_ready) begin
          chk("word_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) chk("out_word", 64'(out_data), 64'(exp_q.pop_front()));
          popped++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (job_done) begin
          done_cnt++;
          chk("job_expected", 64'(exp_ok.size() != 0), 64'(1));
          if (exp_ok.size() != 0) begin
            chk("job_ok", 64'(job_ok), 64'(exp_ok.pop_front()));
            chk("job_tries", 64'(tries), 64'(exp_tr.pop_front()));
          end
        end
      end
    end
  end

  task automatic start_job();
    @(negedge clk);
    job_req = 1'b1;
    wr_seen = 0; rd_issued = 0; popped = 0;
    @(negedge clk);
    job_req = 1'b0;
  endtask

  // stream 32 words; stop_at >= 0 aborts once that many words have been written
  task automatic load_words(input bit fin, input int stop_at);
    int i = 0;
    int g = 0;
    while (i < 32 && g < 2000) begin
      @(negedge clk);
      g++;
      if (i == stop_at) begin
        in_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_load_idle", 64'(busy), 64'(0));
        return;
      end
      in_data  = 4'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) begin
        if (fin) exp_q.push_back(in_data);
        i++;
      end
    end
    chk("load_complete", 64'(i), 64'(32));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic respond(input int kind, input int dly);
    int g = 0;
    while (sys_start !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("start_seen", 64'(sys_start), 64'(1));
    if (kind == K_W) begin
      g = 0;
      while (!(reload_req || job_done) && g < 250) begin
        @(negedge clk);
        g++;
      end
      chk("wd_latency_in_range", 64'(g >= 100 && g <= 103), 64'(1));
    end else begin
      repeat (dly) @(negedge clk);
      sys_success = (kind == K_S || kind == K_B);
      sys_fail    = (kind == K_F || kind == K_B);
      @(negedge clk);
      sys_success = 1'b0;
      sys_fail    = 1'b0;
    end
  endtask

  task automatic run_job(input int k0, input int k1, input int k2, input int n,
                         input int rmode, input bit abort_unload, input int dly);
    int kinds[3];
    bit ok;
    int ntr, s0, r0, d0, g;
    kinds = '{k0, k1, k2};
    ok  = (kinds[n-1] == K_S);
    ntr = ok ? n - 1 : n;
    rdy_mode = rmode;
    stall_left = (rmode == 2) ? 20 : 0;
    s0 = start_cnt; r0 = reload_cnt; d0 = done_cnt;
    if (!abort_unload) begin
      exp_ok.push_back(ok);
      exp_tr.push_back(ntr);
    end
    start_job();
    for (int a = 0; a < n; a++) begin
      load_words((a == n - 1) && ok, -1);
      respond(kinds[a], dly);
    end
    if (abort_unload) begin
      g = 0;
      while (popped < 5 && g < 500) begin
        @(negedge clk);
        g++;
      end
      chk("unload_progress", 64'(popped >= 5), 64'(1));
      abort = 1'b1;
      exp_q.delete();
      @(negedge clk);
      abort = 1'b0;
      chk("abort_unload_idle", 64'(busy), 64'(0));
      chk("abort_unload_flushed", 64'(out_valid), 64'(0));
      repeat (5) @(negedge clk);
      chk("abort_no_done", 64'(done_cnt), 64'(d0));
    end else begin
      g = 0;
      while (done_cnt == d0 && g < 3000) begin
        @(negedge clk);
        g++;
      end
      chk("job_done_seen", 64'(done_cnt), 64'(d0 + 1));
      chk("all_words_out", 64'(exp_q.size()), 64'(0));
      chk("start_count", 64'(start_cnt - s0), 64'(n));
      chk("reload_count", 64'(reload_cnt - r0), 64'(n - 1));
      @(negedge clk);
      chk("idle_after_done", 64'(busy), 64'(0));
      chk("tries_held", 64'(tries), 64'(ntr));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ks[3];
    int n, d0, g;
    rst = 1'b0; job_req = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    sys_success = 1'b0; sys_fail = 1'b0;
    #3;
    chk("reset_outputs", 64'(outs), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", 64'(busy), 64'(0));

    run_job(K_S, K_S, K_S, 1, 0, 0, 10);
    run_job(K_F, K_S, K_S, 2, 0, 0, 10);
    run_job(K_F, K_F, K_F, 3, 0, 0, 10);
    run_job(K_W, K_S, K_S, 2, 0, 0, 10);
    run_job(K_B, K_S, K_S, 2, 0, 0, 10);
    run_job(K_W, K_B, K_F, 3, 1, 0, 5);
    run_job(K_S, K_S, K_S, 1, 1, 0, 4);
    run_job(K_S, K_S, K_S, 1, 2, 0, 4);

    d0 = done_cnt;
    start_job();
    load_words(0, 17);
    repeat (5) @(negedge clk);
    chk("abort_load_no_done", 64'(done_cnt), 64'(d0));
    run_job(K_S, K_S, K_S, 1, 0, 0, 10);
    run_job(K_S, K_S, K_S, 1, 1, 1, 6);
    run_job(K_S, K_S, K_S, 1, 0, 0, 10);

    for (int j = 0; j < 6; j++) begin
      n = $urandom_range(1, 3);
      for (int a = 0; a < 3; a++) ks[a] = $urandom_range(1, 3);
      ks[n-1] = (n == 3) ? $urandom_range(0, 3) : K_S;
      run_job(ks[0], ks[1], ks[2], n, $urandom_range(0, 2), 0, $urandom_range(1, 15));
    end

    rdy_mode = 0;
    start_job();
    load_words(0, -1);
    g = 0;
    while (sys_start !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    repeat (5) @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", 64'(outs), 64'(0));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    run_job(K_F, K_S, K_S, 2, 1, 0, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
